// File: rtl/dir_pulse_gen_pkg.sv
// Shared encodings and default constants for the joystick direction pulse generator.
package dir_pulse_gen_pkg;

   localparam int unsigned POS_W = 10;
   localparam int unsigned CNT_W = 26;

   localparam int unsigned DEF_REPEAT_DELAY  = 40_000_000;
   localparam int unsigned DEF_REPEAT_PERIOD = 15_000_000;
   localparam int unsigned DEF_THRESH_LO     = 256;
   localparam int unsigned DEF_THRESH_HI     = 768;
   localparam int unsigned DEF_HYST          = 32;

   // Deflection state of one joystick axis
   typedef enum logic [1:0] {
      AX_CENTER = 2'd0,
      AX_NEG    = 2'd1,
      AX_POS    = 2'd2
   } axis_state_t;

   // Auto-repeat sequencer state of one axis
   typedef enum logic [1:0] {
      RP_IDLE   = 2'd0,
      RP_DELAY  = 2'd1,
      RP_REPEAT = 2'd2
   } rep_state_t;

endpackage

// File: rtl/dir_pulse_gen_if.sv
// Sample strobe in, four move pulses out.
interface dir_pulse_gen_if;
   import dir_pulse_gen_pkg::*;

   logic             sample_valid;
   logic [POS_W-1:0] x_pos;
   logic [POS_W-1:0] y_pos;
   logic             left;
   logic             right;
   logic             up;
   logic             down;

   modport master (output sample_valid, x_pos, y_pos,
                   input  left, right, up, down);
   modport slave  (input  sample_valid, x_pos, y_pos,
                   output left, right, up, down);
endinterface

// File: rtl/dir_pulse_gen_axis.sv
// One joystick axis: hysteresis classifier, auto-repeat FSM and down-counter.
module dir_axis
   import dir_pulse_gen_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter int unsigned THRESH_LO     = DEF_THRESH_LO,
   parameter int unsigned THRESH_HI     = DEF_THRESH_HI,
   parameter int unsigned HYST          = DEF_HYST
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [POS_W-1:0] i_pos,
   output logic             o_neg,
   output logic             o_pos
);

   localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

   if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
       THRESH_LO + HYST >= THRESH_HI - HYST) begin : g_bad_cfg
      $error("dir_axis: unsupported timing or threshold configuration");
   end

   axis_state_t      r_axis, w_axis_cls, w_axis_nxt;
   rep_state_t       r_rep, w_rep_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_neg, r_pos, w_neg_nxt, w_pos_nxt;
   logic [31:0]      w_pos_ext;
   logic             w_entry, w_release;

   assign w_pos_ext = {{(32-POS_W){1'b0}}, i_pos};

   // Classify the incoming sample against the thresholds with release hysteresis
   always_comb begin
      w_axis_cls = r_axis;
      if (w_pos_ext < THRESH_LO) begin
         w_axis_cls = AX_NEG;
      end else if (w_pos_ext > THRESH_HI) begin
         w_axis_cls = AX_POS;
      end else if (r_axis == AX_NEG && w_pos_ext >= THRESH_LO + HYST) begin
         w_axis_cls = AX_CENTER;
      end else if (r_axis == AX_POS && w_pos_ext <= THRESH_HI - HYST) begin
         w_axis_cls = AX_CENTER;
      end
   end

   assign w_entry   = i_valid && (w_axis_cls != AX_CENTER) && (w_axis_cls != r_axis);
   assign w_release = i_valid && (w_axis_cls == AX_CENTER) && (r_axis != AX_CENTER);

   // Next-state and pulse decode; entry outranks release outranks counter expiry
   always_comb begin
      w_axis_nxt = i_valid ? w_axis_cls : r_axis;
      w_rep_nxt  = r_rep;
      w_cnt_nxt  = r_cnt;
      w_neg_nxt  = 1'b0;
      w_pos_nxt  = 1'b0;
      if (w_entry) begin
         w_rep_nxt = RP_DELAY;
         w_cnt_nxt = DELAY_LD;
         w_neg_nxt = (w_axis_cls == AX_NEG);
         w_pos_nxt = (w_axis_cls == AX_POS);
      end else if (w_release) begin
         w_rep_nxt = RP_IDLE;
         w_cnt_nxt = '0;
      end else if (r_rep != RP_IDLE) begin
         if (r_cnt == '0) begin
            w_rep_nxt = RP_REPEAT;
            w_cnt_nxt = PERIOD_LD;
            w_neg_nxt = (r_axis == AX_NEG);
            w_pos_nxt = (r_axis == AX_POS);
         end else begin
            w_cnt_nxt = r_cnt - 1'b1;
         end
      end
   end

   // State, counter and registered pulse outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_axis <= AX_CENTER;
         r_rep  <= RP_IDLE;
         r_cnt  <= '0;
         r_neg  <= 1'b0;
         r_pos  <= 1'b0;
      end else begin
         r_axis <= w_axis_nxt;
         r_rep  <= w_rep_nxt;
         r_cnt  <= w_cnt_nxt;
         r_neg  <= w_neg_nxt;
         r_pos  <= w_pos_nxt;
      end
   end

   assign o_neg = r_neg;
   assign o_pos = r_pos;

endmodule

// File: rtl/dir_pulse_gen.sv
// Joystick to cursor-move pulse generator: two independent axes with auto-repeat.
module dir_pulse_gen
   import dir_pulse_gen_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter int unsigned THRESH_LO     = DEF_THRESH_LO,
   parameter int unsigned THRESH_HI     = DEF_THRESH_HI,
   parameter int unsigned HYST          = DEF_HYST
) (
   input  logic           clk,
   input  logic           rst,
   dir_pulse_gen_if.slave bus
);

   logic w_x_neg, w_x_pos, w_y_neg, w_y_pos;

   dir_axis #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .THRESH_LO    (THRESH_LO),
      .THRESH_HI    (THRESH_HI),
      .HYST         (HYST)
   ) u_x_axis (
      .clk    (clk),
      .rst    (rst),
      .i_valid(bus.sample_valid),
      .i_pos  (bus.x_pos),
      .o_neg  (w_x_neg),
      .o_pos  (w_x_pos)
   );

   dir_axis #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .THRESH_LO    (THRESH_LO),
      .THRESH_HI    (THRESH_HI),
      .HYST         (HYST)
   ) u_y_axis (
      .clk    (clk),
      .rst    (rst),
      .i_valid(bus.sample_valid),
      .i_pos  (bus.y_pos),
      .o_neg  (w_y_neg),
      .o_pos  (w_y_pos)
   );

   assign bus.left  = w_x_neg;
   assign bus.right = w_x_pos;
   assign bus.down  = w_y_neg;
   assign bus.up    = w_y_pos;

endmodule

// File: doc/dir_pulse_gen.md
DIR_PULSE_GEN -- requirements
Module: dir_pulse_gen

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 40_000_000, meaning clk cycles from the first pulse to the first auto-repeat pulse (400 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_PERIOD, default 15_000_000, meaning clk cycles between auto-repeat pulses.
REQ-003 SHALL have parameter THRESH_LO, default 256, meaning the 10-bit deflection threshold for the negative direction.
REQ-004 SHALL have parameter THRESH_HI, default 768, meaning the 10-bit deflection threshold for the positive direction.
REQ-005 SHALL have parameter HYST, default 32, meaning the release hysteresis in counts.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 sample_valid  input  1  one-cycle strobe; x_pos and y_pos are valid this cycle.
REQ-009 x_pos  input  10  joystick X sample (0 = full left, 1023 = full right).
REQ-010 y_pos  input  10  joystick Y sample (0 = full down, 1023 = full up).
REQ-011 left, right, up, down  output  1 each  one-cycle move pulses to the cursor logic.

Function
REQ-012 Each axis SHALL hold a state in {CENTER, NEG, POS}, updated only on cycles with sample_valid=1.
REQ-013 Axis transitions SHALL be:
- CENTER->NEG when pos < THRESH_LO.
- CENTER->POS when pos > THRESH_HI.
- NEG->CENTER when pos >= THRESH_LO+HYST.
- POS->CENTER when pos <= THRESH_HI-HYST.
- NEG->POS when pos > THRESH_HI, and POS->NEG when pos < THRESH_LO.
- Otherwise the axis holds its state.
REQ-014 Pulse mapping SHALL be: X NEG = left, X POS = right, Y POS = up, Y NEG = down.
REQ-015 Each axis SHALL run a repeat FSM with states IDLE, DELAY and REPEAT, plus a 26-bit down-counter.
REQ-016 On entry to NEG or POS (from CENTER or from the opposite side), the axis SHALL pulse the mapped output for exactly one cycle, registered one cycle after the sample_valid cycle, then enter DELAY with counter = REPEAT_DELAY-1.
REQ-017 In DELAY or REPEAT, the counter SHALL decrement every cycle; when it reaches 0, the axis SHALL pulse once, enter or stay in REPEAT, and reload the counter with REPEAT_PERIOD-1.
REQ-018 On transition to CENTER, the axis SHALL go to IDLE with no pulse, and any pending expiry in that same cycle SHALL be suppressed.
REQ-019 A direction reversal SHALL restart DELAY; at most one output per axis SHALL be high in any cycle.
REQ-020 The X and Y axes SHALL be independent and MAY pulse in the same cycle (diagonal move).
REQ-021 If a counter expiry and an entry event coincide, only the entry pulse SHALL occur and DELAY SHALL restart.
REQ-022 Outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-023 Behaviour with REPEAT_DELAY or REPEAT_PERIOD < 2, or with THRESH_LO+HYST >= THRESH_HI-HYST, is unsupported; an elaboration-time assertion SHALL flag it.

Reset
REQ-024 While rst=1, both axes SHALL be CENTER/IDLE, counters SHALL be 0 and all four outputs SHALL be 0; reset asserted mid-DELAY or mid-REPEAT SHALL abort with no further pulse.
REQ-025 After rst deasserts, a held deflection SHALL produce a pulse only after the next sample_valid (treated as an entry from CENTER).

Structure
REQ-026 A shared package SHALL hold the axis-state encoding {CENTER, NEG, POS}, the repeat-FSM state encoding, and the default threshold and timing constants.
REQ-027 One sub-module, dir_axis, SHALL implement the hysteresis classifier, repeat FSM and counter for one axis; it is instantiated twice, with X and Y mapping done at the top.

Verification
Bench parameters: REPEAT_DELAY=10, REPEAT_PERIOD=4; defaults otherwise.
REQ-028 Single tap: x_pos=100 strobed once at cycle T, then x_pos=512 strobed at T+3 -> left=1 only at T+1, no other pulses.
REQ-029 Hold with repeat: x_pos=900 strobed at T and held -> right pulses at T+1, T+11, T+15, T+19, ...
REQ-030 Hysteresis: Y enters NEG with 200; later samples 270 -> no change; 290 -> CENTER, no pulse; a following 200 -> a new down pulse.
REQ-031 Reversal: X NEG held until cycle T+8, then x_pos=1000 strobed -> right pulse at T+9, next repeat at T+19, and no left pulse after the reversal.
REQ-032 Diagonal plus reset: x=50 and y=1000 strobed together -> left and up are both high in the same cycle; rst held 1 cycle at the DELAY midpoint -> no pulses until the next strobe.
